// File: rtl/uart_tx_seq_if.sv
// Byte-producer / TX-shifter signal bundle for uart_tx_seq.
// master: the side that supplies bytes and observes the shifter controls
// (producer or testbench).
// slave: the sequencer itself.
interface uart_tx_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] sh_data;
  logic       sh_start;
  logic [3:0] sh_cnt;
  logic       sh_bit_en;
  logic       busy;
  logic       frame_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, sh_data, sh_start, sh_cnt, sh_bit_en, busy, frame_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, sh_data, sh_start, sh_cnt, sh_bit_en, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_seq.sv
// UART TX sequencer: accepts bytes on a valid/ready handshake and drives the
// start/cnt/bit-enable controls of an 8-bit LSB-first TX shifter for a
// 10-bit frame (start, D0..D7, stop).
// Optional feature: define UART_TX_FIFO_EN to insert a FIFO_DEPTH-entry input
// FIFO; frames are then chained back to back while the FIFO holds data.
module uart_tx_seq #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input logic         clk,
  input logic         rstn,
  uart_tx_seq_if.slave bus
);

  localparam int DIV_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  // Parameter sanity: a bit slot needs at least two cycles, FIFO depth >= 1.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_seq: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("uart_tx_seq: FIFO_DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [3:0]       bitcnt, bitcnt_nxt;
  logic [7:0]       sh_data;
  logic             load;
  logic             last_tick;

  // Byte source seen by the FSM: either the handshake directly or the FIFO head.
  logic             src_valid;
  logic [7:0]       src_data;
  logic             chain_en;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_pow2
    $error("uart_tx_seq: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = bus.tx_valid && !full;
  assign src_valid = !empty;
  assign src_data  = mem[rd_ptr];
  assign chain_en  = 1'b1;

  assign bus.tx_ready = !full;
  assign bus.busy     = (state != IDLE) || !empty;

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(load);
    end
  end

  // FIFO storage is data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end
`else
  assign src_valid = bus.tx_valid;
  assign src_data  = bus.tx_data;
  assign chain_en  = 1'b0;

  assign bus.tx_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
`endif

  assign last_tick = (div == DIV_W'(CLKS_PER_BIT - 1));

  // State, baud divider, bit counter and latched byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      div     <= '0;
      bitcnt  <= '0;
      sh_data <= 8'h00;
    end else begin
      state  <= state_nxt;
      div    <= div_nxt;
      bitcnt <= bitcnt_nxt;
      if (load) sh_data <= src_data;
    end
  end

  // Next-state logic: slot transitions happen on the last divider cycle.
  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    load       = 1'b0;
    if (state == IDLE || last_tick) div_nxt = '0;
    else                            div_nxt = div + DIV_W'(1);

    unique case (state)
      IDLE: begin
        if (src_valid) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (last_tick) begin
          bitcnt_nxt = 4'd8;
          state_nxt  = DATA;
        end
      end
      DATA: begin
        if (last_tick) begin
          bitcnt_nxt = bitcnt - 4'd1;
          if (bitcnt == 4'd1) state_nxt = STOP;
        end
      end
      STOP: begin
        if (last_tick) begin
          if (chain_en && src_valid) begin
            load      = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shifter controls decoded from registered state only.
  assign bus.sh_data    = sh_data;
  assign bus.sh_start   = (state == START);
  assign bus.sh_cnt     = (state == DATA) ? bitcnt : 4'd0;
  assign bus.sh_bit_en  = (state != IDLE) && (div == '0);
  assign bus.frame_done = (state == STOP) && last_tick;

endmodule

// File: tb/tb_uart_tx_seq.sv
// Randomized self-checking bench for uart_tx_seq (CLKS_PER_BIT=4) with a
// TX shifter model driving txd. A frame-timeline reference model predicts
// every output on each falling clock edge; directed frames pin txd bit
// sequences and enable/frame_done timing with literal values.
module tb_uart_tx_seq;
  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * C;

  logic clk;
  logic rstn;
  uart_tx_seq_if bus ();

  uart_tx_seq #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  // Shifter model: registered txd, LSB first, enabled by sh_bit_en.
  logic       txd;
  logic [7:0] sr;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      txd <= 1'b1;
      sr  <= 8'h00;
    end else if (bus.sh_bit_en) begin
      if (bus.sh_start) begin
        txd <= 1'b0;
        sr  <= bus.sh_data;
      end else if (bus.sh_cnt != 4'd0) begin
        txd <= sr[0];
        sr  <= {1'b0, sr[7:1]};
      end else begin
        txd <= 1'b1;
      end
    end
  end

  // Reference model: a frame is a timeline t = 0..FLEN-1 from START entry.
  bit         m_active;
  int         m_t;
  logic [7:0] m_cur;
  logic [7:0] m_q[$];

  always @(negedge clk) begin
    int   slot;
    logic e_en, e_start, e_done, e_ready, e_busy, pop, accept;
    logic [3:0] e_cnt;
    if (!rstn) begin
      m_active = 1'b0;
      m_t      = 0;
      m_cur    = 8'h00;
      m_q.delete();
    end
    slot    = m_t / C;
    e_en    = m_active && (m_t % C == 0);
    e_start = m_active && (slot == 0);
    e_cnt   = (m_active && slot >= 1 && slot <= 8) ? 4'(9 - slot) : 4'd0;
    e_done  = m_active && (m_t == FLEN - 1);
`ifdef UART_TX_FIFO_EN
    e_ready = (m_q.size() < DEPTH);
    e_busy  = m_active || (m_q.size() != 0);
`else
    e_ready = !m_active;
    e_busy  = m_active;
`endif
    chk("cyc sh_bit_en",  bus.sh_bit_en,  e_en);
    chk("cyc sh_start",   bus.sh_start,   e_start);
    chk("cyc sh_cnt",     bus.sh_cnt,     e_cnt);
    chk("cyc frame_done", bus.frame_done, e_done);
    chk("cyc tx_ready",   bus.tx_ready,   e_ready);
    chk("cyc busy",       bus.busy,       e_busy);
    chk("cyc sh_data",    bus.sh_data,    m_cur);
    if (rstn) begin
      accept = bus.tx_valid && e_ready;
`ifdef UART_TX_FIFO_EN
      pop = (m_q.size() != 0) && (!m_active || m_t == FLEN - 1);
      if (pop) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end else if (m_active) begin
        if (m_t == FLEN - 1) m_active = 1'b0;
        else                 m_t++;
      end
      if (accept) m_q.push_back(bus.tx_data);
`else
      pop = 1'b0;
      if (m_active) begin
        if (m_t == FLEN - 1) m_active = 1'b0;
        else                 m_t++;
      end else if (accept) begin
        m_cur    = bus.tx_data;
        m_active = 1'b1;
        m_t      = 0;
      end
`endif
    end
  end

  task automatic wait_accept(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  // One directed frame: exp_bits[k] is the k-th txd bit on the line.
  task automatic frame(input string name, input logic [7:0] b, input bit hold,
                       input logic [7:0] nb, input logic [9:0] exp_bits);
    bit         ok;
    int         en_bad, st_bad, cnt_bad, rdy_bad, done_at, s;
    logic [9:0] got;
    @(posedge clk); #1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    wait_accept({name, " accept"}, ok);
    if (!ok) return;
    @(posedge clk); #1;
    if (hold) bus.tx_data = nb;
    else      bus.tx_valid = 1'b0;
    en_bad = 0; st_bad = 0; cnt_bad = 0; rdy_bad = 0; done_at = -1; got = '0;
    for (int i = 1; i <= FLEN; i++) begin
      @(negedge clk);
      s = (i - 1) / C;
      if (bus.sh_bit_en !== ((i % C) == 1)) en_bad++;
      if ((bus.sh_start && bus.sh_bit_en) !== (i == 1)) st_bad++;
      if (bus.sh_cnt !== ((s >= 1 && s <= 8) ? 4'(9 - s) : 4'd0)) cnt_bad++;
      if (bus.tx_ready !== 1'b0) rdy_bad++;
      if (bus.frame_done === 1'b1 && done_at < 0) done_at = i;
      if ((i % C) == 3) got[(i - 3) / C] = txd;
    end
    chk({name, " bit_en slots"},    en_bad,  0);
    chk({name, " start qualified"}, st_bad,  0);
    chk({name, " sh_cnt sequence"}, cnt_bad, 0);
    chk({name, " tx_ready low"},    rdy_bad, 0);
    chk({name, " frame_done cyc"},  done_at, FLEN);
    chk({name, " txd bits"},        got,     exp_bits);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at %0t: bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int fd[$];
    rstn         = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    #12;
    chk("rst tx_ready",   bus.tx_ready,   1);
    chk("rst busy",       bus.busy,       0);
    chk("rst sh_bit_en",  bus.sh_bit_en,  0);
    chk("rst sh_cnt",     bus.sh_cnt,     0);
    chk("rst frame_done", bus.frame_done, 0);
    chk("rst txd",        txd,            1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);

`ifdef UART_TX_FIFO_EN
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'(k);
      @(negedge clk);
      chk("fifo push accepted", bus.tx_ready, 1);
    end
    @(posedge clk); #1;
    bus.tx_data = 8'h06;
    @(negedge clk);
    chk("fifo sixth push ready", bus.tx_ready, 0);
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 400 && fd.size() < 5; i++) begin
      @(negedge clk);
      if (bus.frame_done) fd.push_back(i);
    end
    if (fd.size() < 5) timeout("fifo five frames");
    else for (int k = 1; k < 5; k++) chk("fifo frame_done spacing", fd[k] - fd[k-1], FLEN);
    wait_idle("fifo drain");
`else
    // 8'hA5 on the line: 0, 1,0,1,0,0,1,0,1, 1 (index 0 is the start bit).
    frame("A5", 8'hA5, 1'b1, 8'h3C, 10'b11_0100_1010);
    wait_accept("3C after frame_done", ok);
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
`endif

    // Abort a frame in the middle of its data bits.
    @(posedge clk); #1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    wait_accept("5A accept", ok);
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.sh_cnt == 4'd5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("reach sh_cnt 5");
    #2 rstn = 1'b0;
    #1;
    chk("async rst tx_ready",   bus.tx_ready,   1);
    chk("async rst busy",       bus.busy,       0);
    chk("async rst sh_bit_en",  bus.sh_bit_en,  0);
    chk("async rst sh_start",   bus.sh_start,   0);
    chk("async rst sh_cnt",     bus.sh_cnt,     0);
    chk("async rst frame_done", bus.frame_done, 0);
    chk("async rst sh_data",    bus.sh_data,    0);
    chk("async rst txd",        txd,            1);
    @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1;

`ifndef UART_TX_FIFO_EN
    // 8'h0F: 0, 1,1,1,1,0,0,0,0, 1.  8'hFF: 0 then 1 x9.
    frame("0F", 8'h0F, 1'b0, 8'h00, 10'b10_0001_1110);
    frame("FF", 8'hFF, 1'b0, 8'h00, 10'b11_1111_1110);
`endif

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      bus.tx_valid = ($urandom_range(0, 3) == 0);
      bus.tx_data  = 8'($urandom);
    end
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    wait_idle("final drain");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
